// File: rtl/dds_oscillator_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | dds_oscillator_if : control and sample bus of the DDS tone generator        |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
interface dds_oscillator_if #(
  parameter int PHASE_W = 24,
  parameter int DATA_W  = 8,
  parameter int AMP_W   = 8
) ();
  logic               en;
  logic [PHASE_W-1:0] ftw;
  logic               ftw_load;
  logic               phase_rst;
  logic [1:0]         wave_sel;
  logic [AMP_W:0]     amp;
  logic [DATA_W-1:0]  dataout;
  logic               valid;
  logic               wrap;

  modport master (
    output en, ftw, ftw_load, phase_rst, wave_sel, amp,
    input  dataout, valid, wrap
  );

  modport slave (
    input  en, ftw, ftw_load, phase_rst, wave_sel, amp,
    output dataout, valid, wrap
  );
endinterface
`default_nettype wire

// File: rtl/dds_oscillator.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | dds_oscillator : phase-accumulator tone generator, four waveforms, gain    |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module dds_oscillator #(
  parameter int PHASE_W    = 24,
  parameter int LUT_ADDR_W = 8,
  parameter int DATA_W     = 8,
  parameter int AMP_W      = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  dds_oscillator_if.slave        bus_if
);
  localparam int  QW = LUT_ADDR_W - 2;
  localparam int  Q  = 2**QW;
  localparam int  A  = 2**(DATA_W-1) - 1;
  localparam int  PW = DATA_W + AMP_W + 2;
  localparam real PI = 3.14159265358979323846;

  localparam logic [DATA_W-1:0]        MID   = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic signed [DATA_W-1:0] S_POS = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W-1:0] S_NEG = {1'b1, {(DATA_W-2){1'b0}}, 1'b1};
  localparam logic [AMP_W:0]           UNITY = {1'b1, {AMP_W{1'b0}}};

  // Offset-binary to signed, with the lone -M code folded onto -A for symmetry.
  function automatic logic signed [DATA_W-1:0] center(input logic [DATA_W-1:0] u);
    return (u == '0) ? S_NEG : {~u[DATA_W-1], u[DATA_W-2:0]};
  endfunction

  logic [PHASE_W-1:0]        phase_q, phase_d;
  logic                      carry_q, carry_d;
  logic [PHASE_W-1:0]        ftw_q, ftw_d;
  logic signed [DATA_W-1:0]  s1_q;
  logic                      w1_q;
  logic                      v1_q;
  logic [DATA_W-1:0]         dataout_q;
  logic                      valid_q;
  logic                      wrap_q;

  logic [PHASE_W:0]          w_sum;
  logic [DATA_W-2:0]         w_mag [Q+1];
  logic [LUT_ADDR_W-1:0]     w_k;
  logic [QW:0]               w_idx;
  logic [DATA_W-2:0]         w_mag_sel;
  logic [DATA_W:0]           w_tri_p;
  logic [DATA_W-1:0]         w_tri_v;
  logic signed [DATA_W-1:0]  w_wave;
  logic [AMP_W:0]            w_gain;
  logic signed [PW-1:0]      w_prod;
  logic [DATA_W-1:0]         w_sample;
  logic                      w_unused;

  // Quarter-wave magnitudes, indices 0..Q inclusive so the peak is stored.
  for (genvar gi = 0; gi <= Q; gi++) begin : g_mag
    localparam int MAG = $rtoi(A * $sin(2.0 * PI * gi / (4.0 * Q)) + 0.5);
    assign w_mag[gi] = (DATA_W-1)'(MAG);
  end

  assign w_sum = {1'b0, phase_q} + {1'b0, ftw_q};

  always_comb begin
    phase_d = phase_q;
    carry_d = carry_q;
    if (bus_if.phase_rst) begin
      phase_d = '0;
      carry_d = 1'b0;
    end else if (bus_if.en) begin
      {carry_d, phase_d} = w_sum;
    end
    ftw_d = bus_if.ftw_load ? bus_if.ftw : ftw_q;
  end

  assign w_k     = phase_q[PHASE_W-1 -: LUT_ADDR_W];
  assign w_tri_p = phase_q[PHASE_W-1 -: DATA_W+1];
  assign w_tri_v = w_tri_p[DATA_W] ? ~w_tri_p[DATA_W-1:0] : w_tri_p[DATA_W-1:0];

  always_comb begin
    // Odd quadrants read the table backwards from the peak.
    w_idx = {1'b0, w_k[QW-1:0]};
    if (w_k[QW]) begin
      w_idx = (QW+1)'(Q) - {1'b0, w_k[QW-1:0]};
    end
    w_mag_sel = w_mag[w_idx];
    case (bus_if.wave_sel)
      2'd0:    w_wave = w_k[LUT_ADDR_W-1] ? -$signed({1'b0, w_mag_sel})
                                          :  $signed({1'b0, w_mag_sel});
      2'd1:    w_wave = phase_q[PHASE_W-1] ? S_NEG : S_POS;
      2'd2:    w_wave = center(phase_q[PHASE_W-1 -: DATA_W]);
      default: w_wave = center(w_tri_v);
    endcase
  end

  // Bits [AMP_W +: DATA_W] of the two's-complement product are floor(s*g / 2^AMP_W).
  assign w_gain   = (bus_if.amp > UNITY) ? UNITY : bus_if.amp;
  assign w_prod   = PW'(s1_q) * PW'($signed({1'b0, w_gain}));
  assign w_sample = w_prod[AMP_W +: DATA_W] + MID;
  assign w_unused = ^{w_prod[PW-1:AMP_W+DATA_W], w_prod[AMP_W-1:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q   <= '0;
      carry_q   <= 1'b0;
      ftw_q     <= '0;
      s1_q      <= '0;
      w1_q      <= 1'b0;
      v1_q      <= 1'b0;
      dataout_q <= MID;
      valid_q   <= 1'b0;
      wrap_q    <= 1'b0;
    end else begin
      phase_q <= phase_d;
      carry_q <= carry_d;
      ftw_q   <= ftw_d;
      v1_q    <= bus_if.en;
      if (bus_if.en) begin
        s1_q <= w_wave;
        w1_q <= carry_q;
      end
      valid_q <= v1_q;
      wrap_q  <= v1_q & w1_q;
      if (v1_q) begin
        dataout_q <= w_sample;
      end
    end
  end

  assign bus_if.dataout = dataout_q;
  assign bus_if.valid   = valid_q;
  assign bus_if.wrap    = wrap_q;
endmodule
`default_nettype wire
